inst_fetch_unit: RTL and testbench

Instruction fetch front-end between the instruction memory port (`inst_addr_o`/`inst_ce_o`/`inst_i`) and the decode stage. It owns the fetch PC, issues sequential word fetches to a synchronous-read instruction memory, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready handshake. A redirect input, from branch/jump resolution, flushes all buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/inst_fetch_unit.sv | 105 ++++++++++
 tb/tb_inst_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   XLEN             : machine word width
//   NOP_INST         : canonical NOP (addi x0, x0, 0) shown when no instruction is held
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_INC           : sequential fetch stride in bytes
//   fetch_entry_t    : one buffered fetch result, {pc, inst}
//   word_align()     : clears the byte-offset bits of an address
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, inst} pairs.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset (clears pointers and count)
//   flush      : synchronous empty; wins over a simultaneous push
//   push       : write push_data at the tail
//   push_data  : {pc, inst} entry to store
//   pop        : advance the head (caller guarantees non-empty)
//   head_data  : entry at the head (meaningless while empty)
//   count      : current occupancy, 0..DEPTH
//   empty      : occupancy is zero
// Storage is not reset; only pointers and count are control state.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end.
// Owns the fetch PC, issues one word read per cycle to a synchronous-read
// instruction memory while buffer credit allows, and queues returned words with
// their PCs for decode.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   redirect_i      : flush everything buffered / in flight, restart at redirect_pc_i
//   redirect_pc_i   : restart address (low two bits ignored)
//   inst_addr_o     : memory word address (the fetch PC register)
//   inst_ce_o       : memory read request this cycle
//   inst_i          : memory read data, valid the cycle after a request
//   id_valid_o      : head of buffer holds an instruction
//   id_inst_o       : head instruction, NOP when empty
//   id_pc_o         : head PC, 0 when empty
//   id_ready_i      : decode consumes the head this cycle
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_addr_o,
  output logic        inst_ce_o,
  input  logic [31:0] inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    resp;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     outstanding;

  assign pop = id_valid_o & id_ready_i;

  // Credit: buffered + in-flight after this cycle's pop must leave room for
  // one more word. The pop term makes id_ready_i reach inst_ce_o
  // combinationally, which is what sustains one fetch per cycle.
  assign outstanding = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = !rst && !redirect_i && (outstanding < (CW+1)'(FIFO_DEPTH));

  assign inst_ce_o   = issue;
  assign inst_addr_o = fetch_pc;

  // ---- request stage: fetch PC and in-flight tracking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= word_align(redirect_pc_i);
      inflight <= 1'b0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_INC;
      inflight <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= fetch_pc;
  end

  // ---- response stage: memory data joins its PC in the buffer ----
  // A redirect in the response cycle drops the word via flush priority.
  assign push      = inflight & !redirect_i;
  assign resp.pc   = inflight_pc;
  assign resp.inst = inst_i;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // ---- decode interface: registered buffer head, idle values when empty ----
  assign id_valid_o = !fifo_empty;
  assign id_inst_o  = fifo_empty ? NOP_INST : head.inst;
  assign id_pc_o    = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. Inputs change just after the falling
// edge, outputs are sampled 1ns later, state commits on the rising edge.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_addr_o;
  logic        inst_ce_o;
  logic [31:0] inst_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  int          total;
  int          bad;
  logic [31:0] key;

  inst_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_addr_o   (inst_addr_o),
    .inst_ce_o     (inst_ce_o),
    .inst_i        (inst_i),
    .id_valid_o    (id_valid_o),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o),
    .id_ready_i    (id_ready_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: word content is address ^ key; junk when idle.
  always @(posedge clk) begin
    if (inst_ce_o) inst_i <= inst_addr_o ^ key;
    else           inst_i <= $urandom;
  end

  task automatic do_reset(input int n);
    rst = 1'b1; redirect_i = 1'b0; id_ready_i = 1'b0; redirect_pc_i = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = $urandom;
    repeat (2) @(negedge clk);
    #1;
    total++; if (inst_addr_o !== RST_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", inst_addr_o, RST_PC); end
    total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", inst_ce_o); end
    total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    total++; if (id_inst_o !== NOP) begin bad++; $display("FAIL reset_inst: got %h want %h", id_inst_o, NOP); end
    total++; if (id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", id_pc_o); end
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  task automatic test_cold_stream();
    logic [31:0] epc;
    key = 32'hA5A5_0000;
    do_reset(2);
    id_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      total++; if (inst_ce_o !== 1'b1 || inst_addr_o !== 32'(4 * k)) begin bad++; $display("FAIL cold_req c%0d: got ce=%b addr=%h want ce=1 addr=%h", k, inst_ce_o, inst_addr_o, 32'(4 * k)); end
      if (k < 2) begin
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL cold_latency c%0d: got valid=%b want 0", k, id_valid_o); end
      end else begin
        epc = 32'(4 * (k - 2));
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== epc || id_inst_o !== (epc ^ key)) begin bad++; $display("FAIL cold_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, id_valid_o, id_pc_o, id_inst_o, epc, epc ^ key); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    logic [31:0] epc;
    key = $urandom;
    do_reset(2);
    id_ready_i = 1'b0;
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (inst_ce_o === 1'b1) begin
        total++; if (inst_addr_o !== 32'(4 * nreq)) begin bad++; $display("FAIL bp_addr c%0d: got %h want %h", k, inst_addr_o, 32'(4 * nreq)); end
        nreq++;
      end
      if (k >= 2) begin
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== key) begin bad++; $display("FAIL bp_hold c%0d: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", k, id_valid_o, id_pc_o, id_inst_o, key); end
      end
      @(negedge clk);
    end
    total++; if (nreq != DEPTH) begin bad++; $display("FAIL bp_reqcount: got %0d want %0d", nreq, DEPTH); end
    id_ready_i = 1'b1;
    for (int k = 10; k < 20; k++) begin
      #1;
      epc = 32'(4 * (k - 10));
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== epc || id_inst_o !== (epc ^ key)) begin bad++; $display("FAIL bp_drain c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, id_valid_o, id_pc_o, id_inst_o, epc, epc ^ key); end
      total++; if (inst_ce_o !== 1'b1 || inst_addr_o !== 32'(4 * (k - 8))) begin bad++; $display("FAIL bp_refill c%0d: got ce=%b addr=%h want ce=1 addr=%h", k, inst_ce_o, inst_addr_o, 32'(4 * (k - 8))); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] epc;
    key = $urandom;
    do_reset(2);
    id_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      redirect_i    = (k == 5);
      redirect_pc_i = 32'h0000_0103;
      #1;
      if (k == 5) begin
        total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL redir_noissue: got ce=%b want 0", inst_ce_o); end
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'hC || id_inst_o !== (32'hC ^ key)) begin bad++; $display("FAIL redir_pop: got v=%b pc=%h want v=1 pc=0000000c", id_valid_o, id_pc_o); end
      end else if (k == 6 || k == 7) begin
        epc = 32'h100 + 32'(4 * (k - 6));
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL redir_gap c%0d: got valid=%b pc=%h want 0", k, id_valid_o, id_pc_o); end
        total++; if (inst_ce_o !== 1'b1 || inst_addr_o !== epc) begin bad++; $display("FAIL redir_req c%0d: got ce=%b addr=%h want ce=1 addr=%h", k, inst_ce_o, inst_addr_o, epc); end
      end else if (k >= 8) begin
        epc = 32'h100 + 32'(4 * (k - 8));
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== epc || id_inst_o !== (epc ^ key)) begin bad++; $display("FAIL redir_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, id_valid_o, id_pc_o, id_inst_o, epc, epc ^ key); end
      end
      @(negedge clk);
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] epc;
    key = $urandom;
    do_reset(2);
    id_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      redirect_i    = (k == 0);
      redirect_pc_i = 32'hFFFF_FFF8;
      #1;
      if (k >= 1 && k <= 4) begin
        epc = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
        total++; if (inst_ce_o !== 1'b1 || inst_addr_o !== epc) begin bad++; $display("FAIL wrap_req c%0d: got ce=%b addr=%h want ce=1 addr=%h", k, inst_ce_o, inst_addr_o, epc); end
      end
      if (k >= 3) begin
        epc = 32'hFFFF_FFF8 + 32'(4 * (k - 3));
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== epc || id_inst_o !== (epc ^ key)) begin bad++; $display("FAIL wrap_out c%0d: got v=%b pc=%h want v=1 pc=%h", k, id_valid_o, id_pc_o, epc); end
      end
      @(negedge clk);
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    key = $urandom;
    do_reset(2);
    id_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rst        = (k == 5);
      id_ready_i = (k >= 7);
      #1;
      if (k == 4) begin
        total++; if (id_valid_o !== 1'b1 || inst_ce_o !== 1'b0 || inst_addr_o !== 32'h8) begin bad++; $display("FAIL rmid_full: got v=%b ce=%b addr=%h want v=1 ce=0 addr=00000008", id_valid_o, inst_ce_o, inst_addr_o); end
      end
      if (k == 5) begin
        total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL rmid_ce_in_rst: got %b want 0", inst_ce_o); end
      end
      if (k == 6) begin
        total++; if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== NOP) begin bad++; $display("FAIL rmid_outs: got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h", id_valid_o, id_pc_o, id_inst_o, NOP); end
        total++; if (inst_ce_o !== 1'b1 || inst_addr_o !== RST_PC) begin bad++; $display("FAIL rmid_refetch: got ce=%b addr=%h want ce=1 addr=%h", inst_ce_o, inst_addr_o, RST_PC); end
      end
      if (k == 8) begin
        total++; if (id_valid_o !== 1'b1 || id_pc_o !== RST_PC || id_inst_o !== (RST_PC ^ key)) begin bad++; $display("FAIL rmid_first: got v=%b pc=%h want v=1 pc=%h", id_valid_o, id_pc_o, RST_PC); end
      end
      @(negedge clk);
    end
  endtask

  // Reference: every request is a queue entry stamped with its issue cycle; it
  // is visible to decode two cycles later if it has reached the front. A
  // redirect discards the whole queue. Credit = entries held after the pop.
  task automatic test_random();
    logic [31:0] q_pc[$];
    int          q_stamp[$];
    logic [31:0] exp_fetch;
    logic [31:0] rpc;
    logic        exp_vld;
    logic        exp_ce;
    logic        do_pop;
    key = $urandom;
    do_reset(2);
    exp_fetch = RST_PC;
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      redirect_pc_i = rpc;
      #1;
      exp_vld = (q_pc.size() > 0) && (q_stamp[0] + 2 <= cyc);
      total++;
      if (exp_vld) begin
        if (id_valid_o !== 1'b1 || id_pc_o !== q_pc[0] || id_inst_o !== (q_pc[0] ^ key)) begin bad++; $display("FAIL rnd_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", cyc, id_valid_o, id_pc_o, id_inst_o, q_pc[0], q_pc[0] ^ key); end
      end else begin
        if (id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== NOP) begin bad++; $display("FAIL rnd_idle c%0d: got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h", cyc, id_valid_o, id_pc_o, id_inst_o, NOP); end
      end
      do_pop = exp_vld && id_ready_i;
      exp_ce = !redirect_i && ((q_pc.size() - int'(do_pop)) < DEPTH);
      total++; if (inst_ce_o !== exp_ce) begin bad++; $display("FAIL rnd_ce c%0d: got %b want %b", cyc, inst_ce_o, exp_ce); end
      if (exp_ce) begin
        total++; if (inst_addr_o !== exp_fetch) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, inst_addr_o, exp_fetch); end
      end
      if (do_pop) begin
        void'(q_pc.pop_front());
        void'(q_stamp.pop_front());
      end
      if (redirect_i) begin
        q_pc.delete();
        q_stamp.delete();
        exp_fetch = {rpc[31:2], 2'b00};
      end else if (exp_ce) begin
        q_pc.push_back(exp_fetch);
        q_stamp.push_back(cyc);
        exp_fetch = exp_fetch + 32'd4;
      end
      @(negedge clk);
    end
    redirect_i = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    id_ready_i = 1'b0; inst_i = '0; key = '0;
    total = 0; bad = 0;
    @(negedge clk);
    test_reset();
    test_cold_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
